// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code used by the encoder and the Viterbi decoder.
package viterbi_pkg;
  localparam int         K         = 3;
  localparam logic [2:0] G0        = 3'b111;
  localparam logic [2:0] G1        = 3'b101;
  localparam int         TAIL_BITS = K - 1;
  localparam int         PTR_W     = 3;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} fsm_e;
endpackage

// File: rtl/conv_enc_core.sv
// One trellis step of the K=3 encoder: input bit and state {s1,s0} to coded symbol {c0,c1} and next state.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       b,
  input  logic [1:0] s,
  output logic [1:0] symbol,
  output logic [1:0] next_s
);
  logic [2:0] taps;

  // taps[2] is the newest bit, matching the MSB of the octal generators
  assign taps   = {b, s};
  assign symbol = {^(taps & G0), ^(taps & G1)};
  assign next_s = {b, s[1]};
endmodule

// File: rtl/conv_encoder_framer.sv
// Frames a data word into FRAME_BITS+TAIL_BITS coded symbols, MSB-first, with zero tail flush.
module conv_encoder_framer #(
  parameter int FRAME_BITS = 6,
  parameter int TAIL_BITS  = viterbi_pkg::TAIL_BITS,
  parameter int PTR_W      = viterbi_pkg::PTR_W,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [1:0]            symbol_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [PTR_W-1:0]      write_pointer_out,
  output logic                  last_out,
  output logic [CNT_W-1:0]      frame_count
);
  import viterbi_pkg::fsm_e;
  import viterbi_pkg::IDLE;
  import viterbi_pkg::DATA;
  import viterbi_pkg::TAIL;
  import viterbi_pkg::S00;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FRAME_BITS + TAIL_BITS - 1);
  localparam logic [PTR_W-1:0] DATA_LAST = PTR_W'(FRAME_BITS - 1);

  fsm_e                  state, state_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [1:0]            enc_s, enc_s_n;
  logic [1:0]            sym_n;
  logic                  vld_n, last_n;
  logic [PTR_W-1:0]      ptr_n;
  logic [CNT_W-1:0]      fc_n;
  logic                  hs, accept, enc_b;
  logic [1:0]            enc_sym, enc_ns;

  assign hs        = valid_out && ready_in;
  assign ready_out = rst && ((state == IDLE) || (last_out && hs));
  assign accept    = valid_in && ready_out;

  // The core always computes the symbol that will be registered next; the input bit
  // comes from the new word on accept, the shift register in DATA, and zero in the tail.
  always_comb begin
    enc_b = 1'b0;
    if (accept)
      enc_b = data_in[FRAME_BITS-1];
    else if (state == DATA && write_pointer_out != DATA_LAST)
      enc_b = shreg[FRAME_BITS-1];
  end

  conv_enc_core u_core (
    .b      (enc_b),
    .s      (enc_s),
    .symbol (enc_sym),
    .next_s (enc_ns)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    enc_s_n = enc_s;
    sym_n   = symbol_out;
    vld_n   = valid_out;
    ptr_n   = write_pointer_out;
    last_n  = last_out;
    fc_n    = frame_count;

    if (hs && last_out) begin
      fc_n    = frame_count + 1'b1;
      vld_n   = 1'b0;
      last_n  = 1'b0;
      state_n = IDLE;
    end

    if (accept) begin
      shreg_n = data_in << 1;
      enc_s_n = enc_ns;
      sym_n   = enc_sym;
      vld_n   = 1'b1;
      ptr_n   = '0;
      last_n  = 1'b0;
      state_n = DATA;
    end else if (hs && !last_out) begin
      ptr_n   = write_pointer_out + 1'b1;
      shreg_n = shreg << 1;
      enc_s_n = enc_ns;
      sym_n   = enc_sym;
      last_n  = (ptr_n == LAST_PTR);
      state_n = (ptr_n > DATA_LAST) ? TAIL : DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      shreg             <= '0;
      enc_s             <= S00;
      symbol_out        <= '0;
      valid_out         <= 1'b0;
      write_pointer_out <= '0;
      last_out          <= 1'b0;
      frame_count       <= '0;
    end else begin
      state             <= state_n;
      shreg             <= shreg_n;
      enc_s             <= enc_s_n;
      symbol_out        <= sym_n;
      valid_out         <= vld_n;
      write_pointer_out <= ptr_n;
      last_out          <= last_n;
      frame_count       <= fc_n;
    end
  end
endmodule
